// File: rtl/gact_seq_pkg.sv
// Shared constants and state type for the GACT sequence loader.
package gact_seq_pkg;
    localparam int NT_W           = 4;
    localparam int CHARS_PER_WORD = 4;

    localparam logic [NT_W-1:0] NT_N = 4'd0;
    localparam logic [NT_W-1:0] NT_A = 4'd1;
    localparam logic [NT_W-1:0] NT_C = 4'd2;
    localparam logic [NT_W-1:0] NT_G = 4'd3;
    localparam logic [NT_W-1:0] NT_T = 4'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIN  = 2'd2
    } state_e;
endpackage

// File: rtl/gact_seq_loader_ascii2nt.sv
// One ASCII-to-nucleotide conversion lane; purely combinational.
module gact_seq_loader_ascii2nt
    import gact_seq_pkg::*;
(
    input  logic [7:0]      ch_i,
    input  logic            comp_i,
    output logic [NT_W-1:0] nt_o
);

    // Case-insensitive decode, then optional A<->T / C<->G swap
    always_comb begin
        nt_o = NT_N;
        unique case (ch_i)
            8'h41, 8'h61: nt_o = comp_i ? NT_T : NT_A;
            8'h43, 8'h63: nt_o = comp_i ? NT_G : NT_C;
            8'h47, 8'h67: nt_o = comp_i ? NT_C : NT_G;
            8'h54, 8'h74: nt_o = comp_i ? NT_A : NT_T;
            default:      nt_o = NT_N;
        endcase
    end

endmodule

// File: rtl/gact_seq_loader.sv
// Sequence-load controller: packs ASCII base words into 16-bit nt words
// and writes them to the sequence buffer, forward or reverse-ordered.
module gact_seq_loader
    import gact_seq_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  start_len,
    input  logic [ADDR_W-1:0] start_base_addr,
    input  logic              start_complement,
    input  logic              start_reverse,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  n_count
);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  nwords_q, nwords_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              comp_q, comp_d;
    logic              rev_q, rev_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic [LEN_W-1:0]  ncnt_q, ncnt_d;

    logic [CHARS_PER_WORD-1:0][NT_W-1:0] lane_nt;
    logic [CHARS_PER_WORD-1:0][NT_W-1:0] lane_msk;
    logic [CHARS_PER_WORD-1:0]           lane_vld;
    logic [15:0]                         packed_nt;
    logic [2:0]                          n_in_word;
    logic                                last_word;
    logic                                accept;
    logic [LEN_W:0]                      len_plus3;
    logic [LEN_W-1:0]                    word_off;

    // Four conversion lanes, one per byte of the input word
    for (genvar k = 0; k < CHARS_PER_WORD; k++) begin : g_lane
        gact_seq_loader_ascii2nt u_lane (
            .ch_i   (in_data[8*k +: 8]),
            .comp_i (comp_q),
            .nt_o   (lane_nt[k])
        );
    end

    assign accept    = in_valid && in_ready_q;
    assign last_word = (idx_q == nwords_q - LEN_W'(1));
    assign len_plus3 = {1'b0, start_len} + (LEN_W+1)'(3);
    assign word_off  = rev_q ? (nwords_q - LEN_W'(1) - idx_q) : idx_q;

    // Padding mask, N count and in-word lane reversal for the current word
    always_comb begin
        n_in_word = 3'd0;
        packed_nt = 16'd0;
        lane_vld  = '0;
        lane_msk  = '0;
        for (int k = 0; k < CHARS_PER_WORD; k++) begin
            // Only the final word can hold chars past the command length
            lane_vld[k] = !last_word || (len_q[1:0] == 2'd0) || (2'(k) < len_q[1:0]);
            lane_msk[k] = lane_vld[k] ? lane_nt[k] : NT_N;
            if (lane_vld[k] && (lane_nt[k] == NT_N))
                n_in_word = n_in_word + 3'd1;
        end
        for (int k = 0; k < CHARS_PER_WORD; k++) begin
            packed_nt[NT_W*k +: NT_W] = rev_q ? lane_msk[CHARS_PER_WORD-1-k] : lane_msk[k];
        end
    end

    // Command FSM next-state and registered-output next values
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        nwords_d   = nwords_q;
        idx_d      = idx_q;
        base_d     = base_q;
        comp_d     = comp_q;
        rev_d      = rev_q;
        in_ready_d = in_ready_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        ncnt_d     = ncnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d    = start_len;
                    nwords_d = len_plus3[LEN_W:2];
                    base_d   = start_base_addr;
                    comp_d   = start_complement;
                    rev_d    = start_reverse;
                    idx_d    = '0;
                    ncnt_d   = '0;
                    if (start_len == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d    = LOAD;
                        in_ready_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = base_q + ADDR_W'(word_off);
                    wr_data_d = packed_nt;
                    ncnt_d    = ncnt_q + LEN_W'(n_in_word);
                    idx_d     = idx_q + LEN_W'(1);
                    if (last_word) begin
                        in_ready_d = 1'b0;
                        state_d    = FIN;
                    end
                end
            end
            FIN: begin
                // First FIN cycle carries the last write; done follows, then IDLE
                if (!done_q) done_d  = 1'b1;
                else         state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            nwords_q   <= '0;
            idx_q      <= '0;
            base_q     <= '0;
            comp_q     <= 1'b0;
            rev_q      <= 1'b0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            ncnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            nwords_q   <= nwords_d;
            idx_q      <= idx_d;
            base_q     <= base_d;
            comp_q     <= comp_d;
            rev_q      <= rev_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            ncnt_q     <= ncnt_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign n_count  = ncnt_q;

endmodule
